conv_window_feeder: RTL and testbench

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

---
 rtl/conv_window_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// Buffers one IMG_W x IMG_W image and a 7x7 kernel, then streams one kernel row per cycle to a MAC array.
// First beat is registered on the start-accept edge; no backpressure, consumer takes every beat.
module conv_window_feeder #(
    parameter int IMG_W = 11
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic signed [7:0] pix_in,
    input  logic              pix_valid,
    input  logic signed [7:0] wgt_in,
    input  logic              wgt_valid,
    input  logic              start,
    output logic signed [7:0] mac_data0,
    output logic signed [7:0] mac_data1,
    output logic signed [7:0] mac_data2,
    output logic signed [7:0] mac_data3,
    output logic signed [7:0] mac_data4,
    output logic signed [7:0] mac_data5,
    output logic signed [7:0] mac_data6,
    output logic signed [7:0] mac_weight0,
    output logic signed [7:0] mac_weight1,
    output logic signed [7:0] mac_weight2,
    output logic signed [7:0] mac_weight3,
    output logic signed [7:0] mac_weight4,
    output logic signed [7:0] mac_weight5,
    output logic signed [7:0] mac_weight6,
    output logic              mac_en,
    output logic [2:0]        ky,
    output logic [2:0]        oy,
    output logic [2:0]        ox,
    output logic              last_ky,
    output logic              img_full,
    output logic              wgt_full,
    output logic              busy,
    output logic              done
);

    localparam int K     = 7;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int PIX_N = IMG_W * IMG_W;
    localparam int WGT_N = K * K;
    localparam int PA_W  = $clog2(PIX_N);
    localparam int WA_W  = $clog2(WGT_N);
    localparam logic [2:0] LAST_O = 3'(OUT_W - 1);
    localparam logic [2:0] LAST_K = 3'(K - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PA_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [WA_W-1:0]   wgt_cnt_q, wgt_cnt_d;
    logic              img_full_q, img_full_d;
    logic              wgt_full_q, wgt_full_d;
    logic [2:0]        ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
    logic              last_ky_q, mac_en_q, busy_q, done_q;
    logic              beat_d;
    logic signed [7:0] data_q [K];
    logic signed [7:0] data_d [K];
    logic signed [7:0] weight_q [K];
    logic signed [7:0] weight_d [K];
    logic [PA_W-1:0]   pbase;
    logic [WA_W-1:0]   wbase;
    logic              pix_we, wgt_we, accept, final_beat;

    logic signed [7:0] img_mem [PIX_N];
    logic signed [7:0] wgt_mem [WGT_N];

    assign pix_we     = (state_q == S_IDLE) && pix_valid && !img_full_q;
    assign wgt_we     = (state_q == S_IDLE) && wgt_valid && !wgt_full_q;
    assign accept     = (state_q == S_IDLE) && start && img_full_q && wgt_full_q;
    assign final_beat = (ky_q == LAST_K) && (ox_q == LAST_O) && (oy_q == LAST_O);

    always_ff @(posedge clk) begin
        if (pix_we) img_mem[pix_cnt_q] <= pix_in;
        if (wgt_we) wgt_mem[wgt_cnt_q] <= wgt_in;
    end

    // ky_d/ox_d/oy_d always name the beat that will be on the outputs next cycle.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        wgt_cnt_d  = wgt_cnt_q;
        img_full_d = img_full_q;
        wgt_full_d = wgt_full_q;
        ky_d       = 3'd0;
        ox_d       = 3'd0;
        oy_d       = 3'd0;
        beat_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pix_we) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == PA_W'(PIX_N - 1)) img_full_d = 1'b1;
                end
                if (wgt_we) begin
                    wgt_cnt_d = wgt_cnt_q + 1'b1;
                    if (wgt_cnt_q == WA_W'(WGT_N - 1)) wgt_full_d = 1'b1;
                end
                if (accept) begin
                    state_d = S_RUN;
                    beat_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (final_beat) begin
                    state_d    = S_DONE;
                    pix_cnt_d  = '0;
                    wgt_cnt_d  = '0;
                    img_full_d = 1'b0;
                    wgt_full_d = 1'b0;
                end else begin
                    beat_d = 1'b1;
                    oy_d   = oy_q;
                    ox_d   = ox_q;
                    if (ky_q != LAST_K) begin
                        ky_d = ky_q + 3'd1;
                    end else if (ox_q != LAST_O) begin
                        ox_d = ox_q + 3'd1;
                    end else begin
                        ox_d = 3'd0;
                        oy_d = oy_q + 3'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pbase = PA_W'((int'(oy_d) + int'(ky_d)) * IMG_W + int'(ox_d));
        wbase = WA_W'(int'(ky_d) * K);
        for (int k = 0; k < K; k++) begin
            data_d[k]   = beat_d ? img_mem[pbase + PA_W'(k)] : 8'sd0;
            weight_d[k] = beat_d ? wgt_mem[wbase + WA_W'(k)] : 8'sd0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            wgt_cnt_q  <= '0;
            img_full_q <= 1'b0;
            wgt_full_q <= 1'b0;
            ky_q       <= 3'd0;
            ox_q       <= 3'd0;
            oy_q       <= 3'd0;
            last_ky_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < K; k++) begin
                data_q[k]   <= 8'sd0;
                weight_q[k] <= 8'sd0;
            end
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            wgt_cnt_q  <= wgt_cnt_d;
            img_full_q <= img_full_d;
            wgt_full_q <= wgt_full_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            last_ky_q  <= beat_d && (ky_d == LAST_K);
            mac_en_q   <= beat_d;
            busy_q     <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
            for (int k = 0; k < K; k++) begin
                data_q[k]   <= data_d[k];
                weight_q[k] <= weight_d[k];
            end
        end
    end

    assign mac_data0   = data_q[0];
    assign mac_data1   = data_q[1];
    assign mac_data2   = data_q[2];
    assign mac_data3   = data_q[3];
    assign mac_data4   = data_q[4];
    assign mac_data5   = data_q[5];
    assign mac_data6   = data_q[6];
    assign mac_weight0 = weight_q[0];
    assign mac_weight1 = weight_q[1];
    assign mac_weight2 = weight_q[2];
    assign mac_weight3 = weight_q[3];
    assign mac_weight4 = weight_q[4];
    assign mac_weight5 = weight_q[5];
    assign mac_weight6 = weight_q[6];
    assign mac_en      = mac_en_q;
    assign ky          = ky_q;
    assign ox          = ox_q;
    assign oy          = oy_q;
    assign last_ky     = last_ky_q;
    assign img_full    = img_full_q;
    assign wgt_full    = wgt_full_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: scoreboard of expected beats plus a table of hand-derived spot values.
module tb_conv_window_feeder;

    logic              clk = 1'b0;
    logic              rst_b;
    logic signed [7:0] pix_in, wgt_in;
    logic              pix_valid, wgt_valid, start;
    logic signed [7:0] mac_data0, mac_data1, mac_data2, mac_data3, mac_data4, mac_data5, mac_data6;
    logic signed [7:0] mac_weight0, mac_weight1, mac_weight2, mac_weight3, mac_weight4, mac_weight5, mac_weight6;
    logic              mac_en, last_ky, img_full, wgt_full, busy, done;
    logic [2:0]        ky, oy, ox;

    conv_window_feeder #(.IMG_W(11)) dut (
        .clk(clk), .rst_b(rst_b),
        .pix_in(pix_in), .pix_valid(pix_valid), .wgt_in(wgt_in), .wgt_valid(wgt_valid), .start(start),
        .mac_data0(mac_data0), .mac_data1(mac_data1), .mac_data2(mac_data2), .mac_data3(mac_data3),
        .mac_data4(mac_data4), .mac_data5(mac_data5), .mac_data6(mac_data6),
        .mac_weight0(mac_weight0), .mac_weight1(mac_weight1), .mac_weight2(mac_weight2),
        .mac_weight3(mac_weight3), .mac_weight4(mac_weight4), .mac_weight5(mac_weight5),
        .mac_weight6(mac_weight6),
        .mac_en(mac_en), .ky(ky), .oy(oy), .ox(ox), .last_ky(last_ky),
        .img_full(img_full), .wgt_full(wgt_full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      oy, ox, ky;
        logic            last;
        logic [6:0][7:0] d;
        logic [6:0][7:0] w;
    } beat_t;

    typedef struct {
        int         beat;
        logic [2:0] oy, ox, ky;
        logic [7:0] d0, d6, w0, w6;
    } vec_t;

    int                nvec = 0;
    int                nerr = 0;
    logic signed [7:0] m_img [121];
    logic signed [7:0] m_wgt [49];
    beat_t             sbq [$];
    beat_t             cap [175];
    vec_t              tbl [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // pm/wm: 0 -> img=i / w=1, 1 -> img=120-i / w=j; ranges are [from,to)
    task automatic load(input int pm, input int p_from, input int p_to,
                        input int wm, input int w_from, input int w_to);
        int np, nw;
        np = p_to - p_from;
        nw = w_to - w_from;
        for (int c = 0; c < ((np > nw) ? np : nw); c++) begin
            pix_valid = (c < np);
            wgt_valid = (c < nw);
            if (c < np) begin
                pix_in = 8'((pm == 0) ? (p_from + c) : (120 - p_from - c));
                m_img[p_from + c] = pix_in;
            end
            if (c < nw) begin
                wgt_in = 8'((wm == 0) ? 1 : (w_from + c));
                m_wgt[w_from + c] = wgt_in;
            end
            cyc();
        end
        pix_valid = 1'b0;
        wgt_valid = 1'b0;
    endtask

    task automatic push_expected();
        beat_t e;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int r = 0; r < 7; r++) begin
                    e.oy = 3'(y); e.ox = 3'(x); e.ky = 3'(r); e.last = (r == 6);
                    for (int k = 0; k < 7; k++) begin
                        e.d[k] = m_img[(y + r) * 11 + x + k];
                        e.w[k] = m_wgt[r * 7 + k];
                    end
                    sbq.push_back(e);
                end
    endtask

    task automatic run(input bit junk, input int abort_at);
        beat_t act, e;
        int    n;
        bit    aborted;
        n = 0;
        aborted = 1'b0;
        push_expected();
        start = 1'b1;
        if (junk) begin
            pix_valid = 1'b1; pix_in = 8'sh7F;
            wgt_valid = 1'b1; wgt_in = 8'sh7F;
        end
        cyc();
        start = 1'b0;
        while (mac_en === 1'b1 && n < 200) begin
            if (n == abort_at) begin
                rst_b = 1'b0;
                #1;
                check("abort_mac_en", mac_en, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_data", {mac_data0, mac_data3, mac_data6}, 0);
                check("abort_weight", {mac_weight0, mac_weight3, mac_weight6}, 0);
                check("abort_idx", {ky, ox, oy, last_ky}, 0);
                check("abort_full", {img_full, wgt_full}, 0);
                sbq.delete();
                aborted = 1'b1;
                break;
            end
            act.oy = oy; act.ox = ox; act.ky = ky; act.last = last_ky;
            act.d[0] = mac_data0; act.d[1] = mac_data1; act.d[2] = mac_data2; act.d[3] = mac_data3;
            act.d[4] = mac_data4; act.d[5] = mac_data5; act.d[6] = mac_data6;
            act.w[0] = mac_weight0; act.w[1] = mac_weight1; act.w[2] = mac_weight2; act.w[3] = mac_weight3;
            act.w[4] = mac_weight4; act.w[5] = mac_weight5; act.w[6] = mac_weight6;
            if (sbq.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("beat", act, e);
            end
            if (n < 175) cap[n] = act;
            if (junk) check("img_full_in_run", {img_full, busy}, 2'b11);
            n++;
            cyc();
        end
        pix_valid = 1'b0;
        wgt_valid = 1'b0;
        if (!aborted) begin
            check("beat_count", n, 175);
            check("done_pulse", {done, mac_en, busy}, 3'b100);
            check("done_idx_zero", {mac_data0, mac_weight0, ky, ox, oy, last_ky}, 0);
            check("done_fulls_clear", {img_full, wgt_full}, 0);
            check("sb_empty", sbq.size(), 0);
            cyc();
            check("done_one_cycle", {done, mac_en}, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0,   3'd0, 3'd0, 3'd0, 8'd0,   8'd6,   8'd0,  8'd6};
        tbl[1] = '{3,   3'd0, 3'd0, 3'd3, 8'd33,  8'd39,  8'd21, 8'd27};
        tbl[2] = '{6,   3'd0, 3'd0, 3'd6, 8'd66,  8'd72,  8'd42, 8'd48};
        tbl[3] = '{7,   3'd0, 3'd1, 3'd0, 8'd1,   8'd7,   8'd0,  8'd6};
        tbl[4] = '{10,  3'd0, 3'd1, 3'd3, 8'd34,  8'd40,  8'd21, 8'd27};
        tbl[5] = '{35,  3'd1, 3'd0, 3'd0, 8'd11,  8'd17,  8'd0,  8'd6};
        tbl[6] = '{100, 3'd2, 3'd4, 3'd2, 8'd48,  8'd54,  8'd14, 8'd20};
        tbl[7] = '{171, 3'd4, 3'd4, 3'd3, 8'd81,  8'd87,  8'd21, 8'd27};
        tbl[8] = '{174, 3'd4, 3'd4, 3'd6, 8'd114, 8'd120, 8'd42, 8'd48};

        rst_b = 1'b0; pix_in = '0; wgt_in = '0; pix_valid = 1'b0; wgt_valid = 1'b0; start = 1'b0;
        cyc(); cyc();
        check("reset_ctrl", {mac_en, busy, done, img_full, wgt_full}, 0);
        check("reset_out", {mac_data0, mac_data6, mac_weight0, ky, ox, oy, last_ky}, 0);
        rst_b = 1'b1;
        cyc();

        // img=i, w=1, loaded concurrently; fullness edges checked one write short
        load(0, 0, 120, 0, 0, 48);
        check("not_full_120_48", {img_full, wgt_full}, 0);
        load(0, 120, 121, 0, 48, 49);
        check("full_after_last", {img_full, wgt_full}, 2'b11);
        run(1'b0, -1);
        check("runA_first", {cap[0].d[0], cap[0].d[6]}, {8'd0, 8'd6});

        // img=i, w=j, junk writes held during the run
        load(0, 0, 121, 1, 0, 49);
        run(1'b1, -1);
        for (int i = 0; i < 9; i++) begin
            beat_t c;
            c = cap[tbl[i].beat];
            check($sformatf("tbl_beat%0d", tbl[i].beat),
                  {c.oy, c.ox, c.ky, c.last, c.d[0], c.d[6], c.w[0], c.w[6]},
                  {tbl[i].oy, tbl[i].ox, tbl[i].ky, (tbl[i].ky == 3'd6),
                   tbl[i].d0, tbl[i].d6, tbl[i].w0, tbl[i].w6});
        end

        // start with 120 pixels, then on the 121st write, then one cycle later
        load(1, 0, 120, 1, 0, 49);
        start = 1'b1; cyc(); start = 1'b0;
        check("start_120_ignored", {mac_en, busy}, 0);
        pix_valid = 1'b1; pix_in = 8'sd0; m_img[120] = 8'sd0; start = 1'b1;
        cyc();
        pix_valid = 1'b0; start = 1'b0;
        check("start_on_last_ignored", {mac_en, busy, img_full}, 3'b001);
        run(1'b0, -1);
        check("reload_first", {cap[0].d[0], cap[0].d[1], cap[0].d[6]}, {8'd120, 8'd119, 8'd114});

        // abort at beat 80, then start without reload
        load(0, 0, 121, 0, 0, 49);
        run(1'b0, 80);
        cyc();
        check("abort_no_done1", {done, mac_en}, 0);
        cyc();
        check("abort_no_done2", {done, mac_en}, 0);
        rst_b = 1'b1;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("post_abort_start", {mac_en, busy, img_full}, 0);
        cyc();
        check("post_abort_idle", {mac_en, busy, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
